// File: rtl/gnss_sample_capture.sv
// ---------------------------------------------------------------------------
// gnss_sample_capture
//
// Front-end capture stage of the GNSS acquisition/search path.
//
// The block takes the 1-bit IF sample stream (one sample per gnssclk). It packs
// the samples LSB-first into WORD_W-bit words. It then emits a bounded burst of
// capture_len words on a valid/ready stream toward the search engine's sample
// buffer.
//
// Dropped words:
//   - If the consumer stalls, a newly completed word is dropped and the sticky
//     overflow flag is set.
//   - The dropped word still consumes its index, so gaps in out_index mark the
//     drops.
//
// Optional feature (compile-time macro GNSS_CAPTURE_SYNC_EN):
//   - Defined: signal_in passes through a 2-flop synchronizer before packing.
//     The packed sample at edge En is signal_in as sampled at edge E(n-2).
//   - Undefined: signal_in is assumed synchronous to gnssclk and is packed
//     directly.
//
// Ports:
//   gnssclk      in   sample clock, sole clock
//   rst          in   asynchronous reset, active-high
//   signal_in    in   1-bit IF sample
//   start        in   1-cycle capture request (honoured only when idle)
//   abort        in   cancel capture, highest priority after rst
//   capture_len  in   number of words to capture, latched on start accept
//   out_valid    out  out_data/out_index valid
//   out_ready    in   consumer accept (transfer on out_valid && out_ready)
//   out_data     out  packed word, bit k = k-th sample of the word
//   out_index    out  0-based word number within the capture
//   busy         out  capture or drain in progress
//   done         out  1-cycle pulse at normal completion
//   overflow     out  sticky: at least one word dropped in this capture
// ---------------------------------------------------------------------------
module gnss_sample_capture #(
    parameter int WORD_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              gnssclk,
    input  logic              rst,
    input  logic              signal_in,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  capture_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [LEN_W-1:0]  out_index,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int BIT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;

    logic [BIT_W-1:0]    bit_cnt_r;
    logic [LEN_W-1:0]    word_cnt_r;
    logic [LEN_W-1:0]    len_last_r;

    // The top sample of a word is never stored; it is taken straight from
    // sample_s on the completing edge.
    logic [WORD_W-2:0]   shreg_r;

    logic [WORD_W-1:0]   out_data_r;
    logic [LEN_W-1:0]    out_index_r;
    logic                out_valid_r;
    logic                busy_r;
    logic                done_r;
    logic                overflow_r;

    logic                sample_s;
    logic [WORD_W-1:0]   word_s;
    logic                start_acc_s;
    logic                capture_s;
    logic                word_done_s;
    logic                out_free_s;
    logic                accept_s;
    logic                finish_s;

`ifdef GNSS_CAPTURE_SYNC_EN
    logic                sync1_r;
    logic                sync2_r;

    // Two-flop synchronizer for the asynchronous RF front-end sample
    always_ff @(posedge gnssclk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= signal_in;
            sync2_r <= sync1_r;
        end
    end

    assign sample_s = sync2_r;
`else
    assign sample_s = signal_in;
`endif

    // The completed word includes the sample arriving on this edge in the MSB
    assign word_s = {sample_s, shreg_r};

    // Next-state and control-strobe decode; abort overrides every state
    always_comb begin
        state_nx_s  = state_r;
        start_acc_s = 1'b0;
        capture_s   = 1'b0;
        word_done_s = 1'b0;
        finish_s    = 1'b0;
        out_free_s  = (!out_valid_r) || out_ready;
        accept_s    = out_valid_r && out_ready;

        if (abort) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        start_acc_s = 1'b1;
                        if (capture_len == {LEN_W{1'b0}}) begin
                            state_nx_s = ST_DRAIN;
                        end else begin
                            state_nx_s = ST_CAPTURE;
                        end
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    capture_s = 1'b1;
                    if (bit_cnt_r == {BIT_W{1'b1}}) begin
                        word_done_s = 1'b1;
                        if (word_cnt_r == len_last_r) begin
                            state_nx_s = ST_DRAIN;
                        end else begin
                            state_nx_s = ST_CAPTURE;
                        end
                    end else begin
                        state_nx_s = ST_CAPTURE;
                    end
                end
                ST_DRAIN: begin
                    // Leave once the last word has gone, or goes on this edge
                    if (out_free_s) begin
                        finish_s   = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register plus registered busy/done status
    always_ff @(posedge gnssclk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            done_r  <= finish_s;
        end
    end

    // Capture length (stored as last index) latched only on start accept
    always_ff @(posedge gnssclk or posedge rst) begin
        if (rst) begin
            len_last_r <= {LEN_W{1'b0}};
        end else if (start_acc_s) begin
            len_last_r <= capture_len - LEN_W'(1);
        end else begin
            len_last_r <= len_last_r;
        end
    end

    // Bit position within the word being assembled; abort drops the partial word
    always_ff @(posedge gnssclk or posedge rst) begin
        if (rst) begin
            bit_cnt_r <= {BIT_W{1'b0}};
        end else if (abort || start_acc_s) begin
            bit_cnt_r <= {BIT_W{1'b0}};
        end else if (capture_s) begin
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Shift register collecting the lower WORD_W-1 samples of the current word
    always_ff @(posedge gnssclk or posedge rst) begin
        if (rst) begin
            shreg_r <= {(WORD_W-1){1'b0}};
        end else if (capture_s && (bit_cnt_r != {BIT_W{1'b1}})) begin
            shreg_r[bit_cnt_r] <= sample_s;
        end else begin
            shreg_r <= shreg_r;
        end
    end

    // Word counter; counts dropped words too so indices stay time-aligned
    always_ff @(posedge gnssclk or posedge rst) begin
        if (rst) begin
            word_cnt_r <= {LEN_W{1'b0}};
        end else if (start_acc_s) begin
            word_cnt_r <= {LEN_W{1'b0}};
        end else if (word_done_s) begin
            word_cnt_r <= word_cnt_r + LEN_W'(1);
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

    // Output holding register with valid/ready handshake and sticky overflow
    always_ff @(posedge gnssclk or posedge rst) begin
        if (rst) begin
            out_data_r  <= {WORD_W{1'b0}};
            out_index_r <= {LEN_W{1'b0}};
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else if (abort) begin
            // Overflow survives an abort until the next start
            out_valid_r <= 1'b0;
        end else begin
            if (start_acc_s) begin
                overflow_r <= 1'b0;
            end else if (word_done_s && !out_free_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end

            if (word_done_s && out_free_s) begin
                // Covers the accept-and-reload case with no valid bubble
                out_data_r  <= word_s;
                out_index_r <= word_cnt_r;
                out_valid_r <= 1'b1;
            end else if (accept_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_index = out_index_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_gnss_sample_capture.sv
// ---------------------------------------------------------------------------
// tb_gnss_sample_capture
//
// Directed, self-checking bench for gnss_sample_capture with default
// parameters (WORD_W=32, LEN_W=16).
//
// Timing:
//   - Inputs are driven on the falling edge of gnssclk.
//   - Outputs are sampled on the falling edge of gnssclk.
//   - "E<n>" below means the n-th rising edge after the start edge E0.
// ---------------------------------------------------------------------------
module tb_gnss_sample_capture;

    logic        gnssclk;
    logic        rst;
    logic        signal_in;
    logic        start;
    logic        abort;
    logic [15:0] capture_len;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] out_index;
    logic        busy;
    logic        done;
    logic        overflow;

    int          vectors;
    int          miscompares;
    logic        alt;

    gnss_sample_capture #(
        .WORD_W (32),
        .LEN_W  (16)
    ) dut (
        .gnssclk     (gnssclk),
        .rst         (rst),
        .signal_in   (signal_in),
        .start       (start),
        .abort       (abort),
        .capture_len (capture_len),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    initial gnssclk = 1'b0;
    always #5 gnssclk = ~gnssclk;

    // One rising edge; returns at the following falling edge. The alternating
    // pattern then toggles signal_in ready for the next edge.
    task automatic tick();
        @(posedge gnssclk);
        @(negedge gnssclk);
        if (alt) signal_in = ~signal_in;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_t6;
        vectors     = 0;
        miscompares = 0;
        alt         = 1'b0;
        rst         = 1'b1;
        signal_in   = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        capture_len = 16'd0;
        out_ready   = 1'b0;

        // ---- 1: reset state, then zero-length capture ----
        ticks(3);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_data",  {32'd0, out_data},  64'd0);
        check("rst_index", {48'd0, out_index}, 64'd0);
        check("rst_busy",  {63'd0, busy},      64'd0);
        check("rst_done",  {63'd0, done},      64'd0);
        check("rst_ovf",   {63'd0, overflow},  64'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", {63'd0, busy}, 64'd0);

        // abort together with start in IDLE: stay idle
        start = 1'b1; abort = 1'b1; capture_len = 16'd3;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", {63'd0, busy}, 64'd0);
        tick();
        check("abort_start_busy2", {63'd0, busy}, 64'd0);

        capture_len = 16'd0; start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        check("len0_busy_e0",  {63'd0, busy},      64'd1);
        check("len0_done_e0",  {63'd0, done},      64'd0);
        tick();                                   // E1
        check("len0_done_e1",  {63'd0, done},      64'd1);
        check("len0_valid_e1", {63'd0, out_valid}, 64'd0);
        check("len0_busy_e1",  {63'd0, busy},      64'd0);
        tick();                                   // E2
        check("len0_done_e2",  {63'd0, done},      64'd0);

        // ---- 2: 3 words of alternating samples, consumer always ready ----
        // signal_in at E(k) is 1 for odd k (also for negative k, so the
        // synchronized build sees the same phase)
        signal_in = 1'b0; alt = 1'b1; out_ready = 1'b1;
        ticks(2);                                 // E-2 = 0, E-1 = 1
        capture_len = 16'd3; start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        ticks(31);                                // E31
        check("t2_valid_e31", {63'd0, out_valid}, 64'd0);
        tick();                                   // E32
        check("t2_valid_e32", {63'd0, out_valid}, 64'd1);
        check("t2_data0",     {32'd0, out_data},  64'h5555_5555);
        check("t2_index0",    {48'd0, out_index}, 64'd0);
        tick();                                   // E33 accepted
        check("t2_valid_e33", {63'd0, out_valid}, 64'd0);
        ticks(31);                                // E64
        check("t2_valid_e64", {63'd0, out_valid}, 64'd1);
        check("t2_data1",     {32'd0, out_data},  64'h5555_5555);
        check("t2_index1",    {48'd0, out_index}, 64'd1);
        ticks(32);                                // E96
        check("t2_index2",    {48'd0, out_index}, 64'd2);
        check("t2_done_e96",  {63'd0, done},      64'd0);
        check("t2_busy_e96",  {63'd0, busy},      64'd1);
        tick();                                   // E97
        check("t2_done_e97",  {63'd0, done},      64'd1);
        check("t2_busy_e97",  {63'd0, busy},      64'd0);
        check("t2_valid_e97", {63'd0, out_valid}, 64'd0);
        check("t2_ovf",       {63'd0, overflow},  64'd0);
        tick();
        check("t2_done_e98",  {63'd0, done},      64'd0);
        alt = 1'b0;

        // ---- 3: stalled consumer, words 1 and 2 dropped ----
        signal_in = 1'b1; out_ready = 1'b0;
        ticks(2);
        capture_len = 16'd4; start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        ticks(32);                                // E32
        check("t3_valid0", {63'd0, out_valid}, 64'd1);
        check("t3_index0", {48'd0, out_index}, 64'd0);
        check("t3_ovf0",   {63'd0, overflow},  64'd0);
        ticks(32);                                // E64 word 1 dropped
        check("t3_ovf1",   {63'd0, overflow},  64'd1);
        check("t3_index1", {48'd0, out_index}, 64'd0);
        ticks(32);                                // E96 word 2 dropped
        check("t3_index2", {48'd0, out_index}, 64'd0);
        check("t3_data2",  {32'd0, out_data},  64'hFFFF_FFFF);
        out_ready = 1'b1;
        tick();                                   // E97 word 0 accepted
        check("t3_valid_e97", {63'd0, out_valid}, 64'd0);
        ticks(31);                                // E128
        check("t3_valid3", {63'd0, out_valid}, 64'd1);
        check("t3_index3", {48'd0, out_index}, 64'd3);
        tick();                                   // E129
        check("t3_done",   {63'd0, done},      64'd1);
        check("t3_ovf_end",{63'd0, overflow},  64'd1);
        tick();

        // ---- 4: abort during the 2nd word, then a fresh 1-word capture ----
        out_ready = 1'b0; capture_len = 16'd5; start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        check("t4_ovf_cleared", {63'd0, overflow}, 64'd0);
        ticks(32);                                // E32
        check("t4_valid0", {63'd0, out_valid}, 64'd1);
        ticks(7);                                 // E39
        abort = 1'b1;
        tick();                                   // E40
        abort = 1'b0;
        check("t4_abort_busy",  {63'd0, busy},      64'd0);
        check("t4_abort_valid", {63'd0, out_valid}, 64'd0);
        check("t4_abort_done",  {63'd0, done},      64'd0);
        tick();
        check("t4_abort_done2", {63'd0, done},      64'd0);
        out_ready = 1'b1; capture_len = 16'd1; start = 1'b1;
        tick();                                   // E0'
        start = 1'b0;
        ticks(32);                                // E32'
        check("t4_restart_valid", {63'd0, out_valid}, 64'd1);
        check("t4_restart_index", {48'd0, out_index}, 64'd0);
        tick();                                   // E33'
        check("t4_restart_done",  {63'd0, done},      64'd1);
        tick();

        // ---- 5: start while busy is ignored ----
        capture_len = 16'd2; start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        ticks(4);                                 // E4
        capture_len = 16'd9; start = 1'b1;
        tick();                                   // E5
        start = 1'b0;
        ticks(27);                                // E32
        check("t5_index0", {48'd0, out_index}, 64'd0);
        ticks(32);                                // E64
        check("t5_index1", {48'd0, out_index}, 64'd1);
        tick();                                   // E65
        check("t5_done",   {63'd0, done},      64'd1);
        check("t5_busy",   {63'd0, busy},      64'd0);
        ticks(40);
        check("t5_no_more",{63'd0, out_valid}, 64'd0);

        // ---- 6: single-cycle sample at the start edge ----
        signal_in = 1'b0; out_ready = 1'b0;
        ticks(3);
        signal_in = 1'b1; capture_len = 16'd1; start = 1'b1;
        tick();                                   // E0
        signal_in = 1'b0; start = 1'b0;
        ticks(32);                                // E32
`ifdef GNSS_CAPTURE_SYNC_EN
        exp_t6 = 32'h0000_0002;
`else
        exp_t6 = 32'h0000_0000;
`endif
        check("t6_valid", {63'd0, out_valid}, 64'd1);
        check("t6_data",  {32'd0, out_data},  {32'd0, exp_t6});
        out_ready = 1'b1;
        tick();
        check("t6_done",  {63'd0, done},      64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
